// File: rtl/sync_frames_pkg.sv
// sync_frames_pkg
// Shared types and default sizes for the parametrised frame synchroniser.
// Contents:
//   state_t        - controller state (IDLE, ARMED, COLLECT), 2 bits
//   NCHN_DEFAULT   - default number of sensor channels
//   TMO_W_DEFAULT  - default width of the timeout value and cycle counter
// Optional feature macro used by the top level: SYNC_FRAMES_SKEW_EN
package sync_frames_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COLLECT = 2'd2
  } state_t;

  localparam int NCHN_DEFAULT  = 4;
  localparam int TMO_W_DEFAULT = 16;

endpackage

// File: rtl/sync_frames_edge.sv
// sync_frames_edge
// Falling-edge detector for the active-low external trigger. The trigger is
// registered once into a history flop, and the detected edge is registered
// again, so o_trigs is a clean single-cycle pulse one cycle after the first
// clock edge that samples i_trig low.
// Ports:
//   clk     - clock, all logic on posedge
//   rst     - asynchronous active-high reset
//   i_trig  - active-low trigger input
//   o_trigs - registered single-cycle falling-edge pulse
module sync_frames_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_trig,
  output logic o_trigs
);

  logic r_trig_d;
  logic r_trigs;
  logic w_edge;

  // History resets to 0 so a trigger held low out of reset never looks like
  // a falling edge; this is what gives the free-running mode.
  assign w_edge = r_trig_d & ~i_trig;

  // Trigger history and registered edge pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trig_d <= 1'b0;
      r_trigs  <= 1'b0;
    end else begin
      r_trig_d <= i_trig;
      r_trigs  <= w_edge;
    end
  end

  assign o_trigs = r_trigs;

endmodule

// File: rtl/sync_frames_n.sv
// sync_frames_n
// Aligns frame-start pulses from NCHN sensor channels to an external trigger.
// After a trigger arms the block, the first enabled channel that reports vact
// causes one simultaneous sync pulse on every enabled channel; the remaining
// channels' vacts are then swallowed until all have reported, a programmable
// timeout expires, or a new trigger re-arms the block. Channels not waiting
// on a trigger pass their vact straight through with one cycle of latency.
// Ports:
//   clk     - clock, all logic on posedge
//   rst     - asynchronous active-high reset
//   trig    - active-low trigger (held low for free-running mode)
//   vacts   - per-channel single-cycle frame-start pulses
//   enchn   - per-channel enables
//   tmo     - timeout in clk cycles, 0 disables the timeout
//   first   - pulse: first enabled vact after arming
//   sync    - per-channel sync pulses
//   busy    - high while ARMED or COLLECT
//   timeout - pulse when a collection is aborted by the timeout
//   missed  - channels still pending at abort or re-arm (held)
//   skew    - cycles from first to the last pending vact
// Optional feature: define SYNC_FRAMES_SKEW_EN to drive skew; otherwise skew
// is tied to zero. The port list is the same in both builds.
module sync_frames_n
  import sync_frames_pkg::*;
#(
  parameter int NCHN  = NCHN_DEFAULT,
  parameter int TMO_W = TMO_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [NCHN-1:0]  vacts,
  input  logic [NCHN-1:0]  enchn,
  input  logic [TMO_W-1:0] tmo,
  output logic             first,
  output logic [NCHN-1:0]  sync,
  output logic             busy,
  output logic             timeout,
  output logic [NCHN-1:0]  missed,
  output logic [TMO_W-1:0] skew
);

  logic             w_trigs;
  logic             w_rearm;
  logic [NCHN-1:0]  w_pend;
  logic [NCHN-1:0]  w_hit;
  logic [NCHN-1:0]  w_remain;
  logic [NCHN-1:0]  w_pass;
  logic             w_tmo_hit;
  logic             w_done_armed;
  logic             w_done_collect;

  state_t           r_state;
  logic [NCHN-1:0]  r_pending;
  logic [TMO_W-1:0] r_counter;
  logic             r_first;
  logic [NCHN-1:0]  r_sync;
  logic             r_busy;
  logic             r_timeout;
  logic [NCHN-1:0]  r_missed;

  sync_frames_edge u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_trig  (trig),
    .o_trigs (w_trigs)
  );

  // A trigger with no channel enabled has nothing to wait for and is ignored.
  assign w_rearm = w_trigs & (|enchn);

  // Pending is always masked by the live enables, so a channel disabled
  // mid-operation silently drops out and is never reported as missed.
  assign w_pend   = r_pending & enchn;
  assign w_hit    = vacts & w_pend;
  assign w_remain = w_pend & ~vacts;
  assign w_pass   = enchn & vacts & ~w_pend;

  // The counter reads tmo-1 while the vacts of the last allowed cycle are
  // sampled, so the timeout pulse lands exactly tmo cycles after first.
  // The >= keeps a run from escaping if tmo is lowered mid-collection.
  assign w_tmo_hit = (tmo != '0) && (r_counter >= (tmo - TMO_W'(1)));

  assign w_done_armed   = !w_rearm && (r_state == ARMED) && (|w_hit) &&
                          (w_remain == '0);
  assign w_done_collect = !w_rearm && (r_state == COLLECT) && (w_remain == '0);

  // Controller: state, pending set, cycle counter and all registered outputs.
  // A re-arm takes priority over everything; a vact arriving in the same
  // cycle is judged against the new pending set, so it neither passes
  // through nor counts as the first vact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_counter <= '0;
      r_first   <= 1'b0;
      r_sync    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_missed  <= '0;
    end else begin
      r_first   <= 1'b0;
      r_timeout <= 1'b0;
      r_sync    <= w_pass;
      r_pending <= w_pend;
      if (w_rearm) begin
        if (r_state == COLLECT) begin
          r_missed <= w_pend;
        end
        r_state   <= ARMED;
        r_busy    <= 1'b1;
        r_pending <= enchn;
        r_counter <= '0;
        r_sync    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_busy <= 1'b0;
          end
          ARMED: begin
            if (|w_hit) begin
              r_first   <= 1'b1;
              r_sync    <= enchn;
              r_pending <= w_remain;
              r_counter <= '0;
              if (w_remain == '0) begin
                r_state  <= IDLE;
                r_busy   <= 1'b0;
                r_missed <= '0;
              end else begin
                r_state <= COLLECT;
                r_busy  <= 1'b1;
              end
            end else if (w_pend == '0) begin
              // Every armed channel was disabled before any fired.
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          COLLECT: begin
            r_pending <= w_remain;
            if (r_counter != '1) begin
              r_counter <= r_counter + TMO_W'(1);
            end
            if (w_remain == '0) begin
              r_state  <= IDLE;
              r_busy   <= 1'b0;
              r_missed <= '0;
            end else if (w_tmo_hit) begin
              r_timeout <= 1'b1;
              r_missed  <= w_remain;
              r_pending <= '0;
              r_state   <= IDLE;
              r_busy    <= 1'b0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_pending <= '0;
          end
        endcase
      end
    end
  end

`ifdef SYNC_FRAMES_SKEW_EN
  logic [TMO_W-1:0] r_skew;

  // Skew is loaded only on normal completion; timeouts and re-arms keep the
  // last measured value. Completing straight from ARMED means all channels
  // fired together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skew <= '0;
    end else if (w_done_armed) begin
      r_skew <= '0;
    end else if (w_done_collect) begin
      r_skew <= r_counter;
    end
  end

  assign skew = r_skew;
`else
  assign skew = '0;
`endif

  assign first   = r_first;
  assign sync    = r_sync;
  assign busy    = r_busy;
  assign timeout = r_timeout;
  assign missed  = r_missed;

endmodule

// File: tb/tb_sync_frames_n.sv
// tb_sync_frames_n
// Directed bench for sync_frames_n with NCHN=4, TMO_W=16. Expected skew
// values follow SYNC_FRAMES_SKEW_EN when the bench is built with it.
module tb_sync_frames_n;

  logic        clk;
  logic        rst;
  logic        trig;
  logic [3:0]  vacts;
  logic [3:0]  enchn;
  logic [15:0] tmo;
  logic        first;
  logic [3:0]  sync;
  logic        busy;
  logic        timeout;
  logic [3:0]  missed;
  logic [15:0] skew;

  int testsRun;
  int testsFailed;

`ifdef SYNC_FRAMES_SKEW_EN
  localparam logic [15:0] SkewBasic = 16'd1;
  localparam logic [15:0] SkewRearm = 16'd0;
  localparam logic [15:0] SkewLong  = 16'd7;
`else
  localparam logic [15:0] SkewBasic = 16'd0;
  localparam logic [15:0] SkewRearm = 16'd0;
  localparam logic [15:0] SkewLong  = 16'd0;
`endif

  sync_frames_n #(
    .NCHN  (4),
    .TMO_W (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .vacts   (vacts),
    .enchn   (enchn),
    .tmo     (tmo),
    .first   (first),
    .sync    (sync),
    .busy    (busy),
    .timeout (timeout),
    .missed  (missed),
    .skew    (skew)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and return 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic t, input logic [3:0] v, input logic [3:0] e);
    trig  = t;
    vacts = v;
    enchn = e;
    @(posedge clk);
    #1;
  endtask

  // One comparison, counted and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Trigger high for a cycle, then low: after the third cycle the block is ARMED.
  task automatic armDut(input logic [3:0] e);
    applyStimulus(1'b1, 4'b0000, e);
    applyStimulus(1'b0, 4'b0000, e);
    applyStimulus(1'b0, 4'b0000, e);
  endtask

  // Linear sequence of directed steps.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst   = 1'b1;
    trig  = 1'b0;
    vacts = 4'b0000;
    enchn = 4'b0000;
    tmo   = 16'd0;
    @(posedge clk);
    #1;
    checkOutput("rstFirst", {15'd0, first}, 16'd0);
    checkOutput("rstSync", {12'd0, sync}, 16'd0);
    checkOutput("rstBusy", {15'd0, busy}, 16'd0);
    checkOutput("rstMissed", {12'd0, missed}, 16'd0);
    checkOutput("rstSkew", skew, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] free-running pass-through");
    applyStimulus(1'b0, 4'b0100, 4'b1011);
    checkOutput("freeDisabledCh", {12'd0, sync}, 16'd0);
    applyStimulus(1'b0, 4'b0001, 4'b1011);
    checkOutput("freeSync", {12'd0, sync}, 16'h1);
    checkOutput("freeFirst", {15'd0, first}, 16'd0);
    checkOutput("freeBusy", {15'd0, busy}, 16'd0);
    applyStimulus(1'b0, 4'b0000, 4'b1011);
    checkOutput("freeSyncClear", {12'd0, sync}, 16'd0);

    $display("[TB] basic sync");
    tmo = 16'd100;
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b0, 4'b0000, 4'b1111);
    checkOutput("armLatency", {15'd0, busy}, 16'd0);
    applyStimulus(1'b0, 4'b0000, 4'b1111);
    checkOutput("armedBusy", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 4'b0010, 4'b1111);
    checkOutput("basicFirst", {15'd0, first}, 16'd1);
    checkOutput("basicSync", {12'd0, sync}, 16'hF);
    applyStimulus(1'b0, 4'b0001, 4'b1111);
    checkOutput("basicSwallow1", {12'd0, sync}, 16'd0);
    checkOutput("basicFirstPulse", {15'd0, first}, 16'd0);
    checkOutput("basicBusyMid", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 4'b1100, 4'b1111);
    checkOutput("basicSwallow2", {12'd0, sync}, 16'd0);
    checkOutput("basicBusyDone", {15'd0, busy}, 16'd0);
    checkOutput("basicMissed", {12'd0, missed}, 16'd0);
    checkOutput("basicSkew", skew, SkewBasic);
    applyStimulus(1'b0, 4'b0100, 4'b1111);
    checkOutput("basicPassAfter", {12'd0, sync}, 16'h4);

    $display("[TB] timeout");
    tmo = 16'd10;
    armDut(4'b0111);
    applyStimulus(1'b0, 4'b0001, 4'b0111);
    checkOutput("tmoFirst", {15'd0, first}, 16'd1);
    checkOutput("tmoSync", {12'd0, sync}, 16'h7);
    applyStimulus(1'b0, 4'b0010, 4'b0111);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0111);
      checkOutput("tmoEarly", {15'd0, timeout}, 16'd0);
    end
    checkOutput("tmoBusyWait", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 4'b0000, 4'b0111);
    checkOutput("tmoPulse", {15'd0, timeout}, 16'd1);
    checkOutput("tmoMissed", {12'd0, missed}, 16'h4);
    checkOutput("tmoBusy", {15'd0, busy}, 16'd0);
    checkOutput("tmoSkewHeld", skew, SkewBasic);
    applyStimulus(1'b0, 4'b0100, 4'b0111);
    checkOutput("tmoPulseEnd", {15'd0, timeout}, 16'd0);
    checkOutput("tmoMissedHeld", {12'd0, missed}, 16'h4);
    checkOutput("tmoIdlePass", {12'd0, sync}, 16'h4);

    $display("[TB] re-arm during collect");
    tmo = 16'd0;
    armDut(4'b1111);
    applyStimulus(1'b0, 4'b0111, 4'b1111);
    checkOutput("rearmFirst1", {15'd0, first}, 16'd1);
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b0, 4'b0000, 4'b1111);
    applyStimulus(1'b0, 4'b0100, 4'b1111);
    checkOutput("rearmMissed", {12'd0, missed}, 16'h8);
    checkOutput("rearmNoTimeout", {15'd0, timeout}, 16'd0);
    checkOutput("rearmBusy", {15'd0, busy}, 16'd1);
    checkOutput("rearmPriority", {12'd0, sync}, 16'd0);
    checkOutput("rearmNoFirst", {15'd0, first}, 16'd0);
    applyStimulus(1'b0, 4'b1000, 4'b1111);
    checkOutput("rearmFirst2", {15'd0, first}, 16'd1);
    checkOutput("rearmSync", {12'd0, sync}, 16'hF);
    applyStimulus(1'b0, 4'b0111, 4'b1111);
    checkOutput("rearmDoneMissed", {12'd0, missed}, 16'd0);
    checkOutput("rearmDoneBusy", {15'd0, busy}, 16'd0);
    checkOutput("rearmSkew", skew, SkewRearm);

    $display("[TB] enable change during collect");
    armDut(4'b1111);
    applyStimulus(1'b0, 4'b1001, 4'b1111);
    checkOutput("enFirst", {15'd0, first}, 16'd1);
    applyStimulus(1'b0, 4'b0000, 4'b1101);
    checkOutput("enBusy", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 4'b0100, 4'b1101);
    checkOutput("enDoneBusy", {15'd0, busy}, 16'd0);
    checkOutput("enMissed", {12'd0, missed}, 16'd0);
    checkOutput("enSwallow", {12'd0, sync}, 16'd0);

    $display("[TB] skew and reset");
    armDut(4'b0011);
    applyStimulus(1'b0, 4'b0001, 4'b0011);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b0, 4'b0000, 4'b0011);
    end
    checkOutput("skewBusy", {15'd0, busy}, 16'd1);
    applyStimulus(1'b0, 4'b0010, 4'b0011);
    checkOutput("skewDoneBusy", {15'd0, busy}, 16'd0);
    checkOutput("skewValue", skew, SkewLong);
    armDut(4'b0011);
    applyStimulus(1'b0, 4'b0001, 4'b0011);
    checkOutput("rstMidFirst", {15'd0, first}, 16'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstMidFirst0", {15'd0, first}, 16'd0);
    checkOutput("rstMidSync", {12'd0, sync}, 16'd0);
    checkOutput("rstMidBusy", {15'd0, busy}, 16'd0);
    checkOutput("rstMidSkew", skew, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 4'b0010, 4'b0011);
    checkOutput("rstMidPass", {12'd0, sync}, 16'h2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
